// File: rtl/serial_parity_pkg.sv
// Shared types and constants for the serial parity receiver.
package serial_parity_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity
  } state_e;

  localparam int unsigned PAR_EVEN = 0;
  localparam int unsigned PAR_ODD  = 1;

  // Bit counter must hold 0..data_w inclusive.
  function automatic int unsigned cnt_width(input int unsigned data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/serial_parity_checker_if.sv
// Serial input and framed-output bundle of the parity receiver.
interface serial_parity_checker_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
);
  logic              ser_valid;
  logic              ser_bit;
  logic              frame_start;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_perr;
  logic              sync_err;
  logic              overrun;
  logic [CNT_W-1:0]  err_count;
  logic              err_clr;

  // Receiver side.
  modport slave (
    input  ser_valid, ser_bit, frame_start, out_ready, err_clr,
    output out_valid, out_data, out_perr, sync_err, overrun, err_count
  );

  // Stimulus / consumer side.
  modport master (
    output ser_valid, ser_bit, frame_start, out_ready, err_clr,
    input  out_valid, out_data, out_perr, sync_err, overrun, err_count
  );
endinterface

// File: rtl/ser_shift_reg.sv
// MSB-first deserializing shift register with a fill counter.
module ser_shift_reg
  import serial_parity_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,      // start a new frame with bit_in as its MSB
  input  logic              shift,     // append bit_in to the current frame
  input  logic              bit_in,
  output logic [DATA_W-1:0] data,
  output logic              next_full  // the next shift completes the data field
);

  localparam int unsigned CntBits = cnt_width(DATA_W);

  logic [DATA_W-1:0]  data_d, data_q;
  logic [CntBits-1:0] cnt_d, cnt_q;

  // Load restarts the frame; shift appends at the LSB end.
  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (load) begin
      data_d = DATA_W'(bit_in);
      cnt_d  = CntBits'(1);
    end else if (shift) begin
      data_d = (data_q << 1) | DATA_W'(bit_in);
      cnt_d  = cnt_q + CntBits'(1);
    end
  end

  // Shift register and counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign data      = data_q;
  assign next_full = (cnt_q == CntBits'(DATA_W - 1));

endmodule

// File: rtl/serial_parity_checker.sv
// Bit-serial parity-checked byte receiver with valid/ready output and error count.
module serial_parity_checker
  import serial_parity_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ODD_PARITY = PAR_EVEN,
  parameter int unsigned CNT_W      = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  serial_parity_checker_if.slave bus
);

  localparam logic   OddBit     = (ODD_PARITY != PAR_EVEN);
  // A one-bit data field goes straight to the parity bit.
  localparam state_e FirstState = (DATA_W == 1) ? StParity : StData;

  state_e            state_d, state_q;
  logic              load, shift, abort, frame_done, frame_perr, next_full;
  logic [DATA_W-1:0] sr_data;

  logic              out_valid_d, out_valid_q;
  logic [DATA_W-1:0] out_data_d, out_data_q;
  logic              out_perr_d, out_perr_q;
  logic              sync_err_d, sync_err_q;
  logic              overrun_d, overrun_q;
  logic              err_inc;
  logic [CNT_W-1:0]  err_count_d, err_count_q;

  ser_shift_reg #(
    .DATA_W (DATA_W)
  ) u_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .shift     (shift),
    .bit_in    (bus.ser_bit),
    .data      (sr_data),
    .next_full (next_full)
  );

  assign frame_perr = (^sr_data) ^ bus.ser_bit ^ OddBit;

  // Frame FSM: only cycles with ser_valid advance it; frame_start always restarts.
  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    shift      = 1'b0;
    abort      = 1'b0;
    frame_done = 1'b0;
    if (bus.ser_valid) begin
      unique case (state_q)
        StIdle: begin
          if (bus.frame_start) begin
            load    = 1'b1;
            state_d = FirstState;
          end
        end
        StData: begin
          if (bus.frame_start) begin
            load    = 1'b1;
            abort   = 1'b1;
            state_d = FirstState;
          end else begin
            shift   = 1'b1;
            state_d = next_full ? StParity : StData;
          end
        end
        StParity: begin
          if (bus.frame_start) begin
            load    = 1'b1;
            abort   = 1'b1;
            state_d = FirstState;
          end else begin
            frame_done = 1'b1;
            state_d    = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Output slot: a completed frame loads only if the slot is empty or draining.
  always_comb begin
    out_valid_d = out_valid_q && !bus.out_ready;
    out_data_d  = out_data_q;
    out_perr_d  = out_perr_q;
    overrun_d   = 1'b0;
    sync_err_d  = abort;
    err_inc     = 1'b0;
    if (frame_done) begin
      if (!out_valid_q || bus.out_ready) begin
        out_valid_d = 1'b1;
        out_data_d  = sr_data;
        out_perr_d  = frame_perr;
        err_inc     = frame_perr;
      end else begin
        overrun_d = 1'b1;
      end
    end
    if (bus.err_clr) begin
      err_count_d = '0;
    end else if (err_inc && (err_count_q != {CNT_W{1'b1}})) begin
      err_count_d = err_count_q + CNT_W'(1);
    end else begin
      err_count_d = err_count_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_perr_q  <= 1'b0;
      sync_err_q  <= 1'b0;
      overrun_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_perr_q  <= out_perr_d;
      sync_err_q  <= sync_err_d;
      overrun_q   <= overrun_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_perr  = out_perr_q;
  assign bus.sync_err  = sync_err_q;
  assign bus.overrun   = overrun_q;
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_serial_parity_checker.sv
// Scoreboard bench: an even-parity and an odd-parity receiver see the same serial stream.
module tb_serial_parity_checker;
  import serial_parity_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 8;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
  } exp_t;

  logic clk;
  logic rst_n;
  logic ser_valid, ser_bit, frame_start, out_ready, err_clr;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t q_e[$];
  exp_t q_o[$];
  exp_t got_e, got_o;
  int   sync_cnt_e = 0, sync_cnt_o = 0, ovr_cnt_e = 0, ovr_cnt_o = 0;

  serial_parity_checker_if #(.DATA_W(DW), .CNT_W(CW)) bus_e ();
  serial_parity_checker_if #(.DATA_W(DW), .CNT_W(CW)) bus_o ();

  assign bus_e.ser_valid   = ser_valid;
  assign bus_e.ser_bit     = ser_bit;
  assign bus_e.frame_start = frame_start;
  assign bus_e.out_ready   = out_ready;
  assign bus_e.err_clr     = err_clr;
  assign bus_o.ser_valid   = ser_valid;
  assign bus_o.ser_bit     = ser_bit;
  assign bus_o.frame_start = frame_start;
  assign bus_o.out_ready   = out_ready;
  assign bus_o.err_clr     = err_clr;

  serial_parity_checker #(
    .DATA_W     (DW),
    .ODD_PARITY (PAR_EVEN),
    .CNT_W      (CW)
  ) dut_e (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_e)
  );

  serial_parity_checker #(
    .DATA_W     (DW),
    .ODD_PARITY (PAR_ODD),
    .CNT_W      (CW)
  ) dut_o (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: pop and compare on every output handshake; count status pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_e.sync_err) sync_cnt_e++;
      if (bus_o.sync_err) sync_cnt_o++;
      if (bus_e.overrun) ovr_cnt_e++;
      if (bus_o.overrun) ovr_cnt_o++;
      if (bus_e.out_valid && out_ready) begin
        if (q_e.size() == 0) begin
          n_checks++;
          $display("FAIL even_unexpected_out: got data %0h, expected no output", bus_e.out_data);
        end else begin
          got_e = q_e.pop_front();
          check("even_out_data", 32'(bus_e.out_data), 32'(got_e.data));
          check("even_out_perr", 32'(bus_e.out_perr), 32'(got_e.perr));
        end
      end
      if (bus_o.out_valid && out_ready) begin
        if (q_o.size() == 0) begin
          n_checks++;
          $display("FAIL odd_unexpected_out: got data %0h, expected no output", bus_o.out_data);
        end else begin
          got_o = q_o.pop_front();
          check("odd_out_data", 32'(bus_o.out_data), 32'(got_o.data));
          check("odd_out_perr", 32'(bus_o.out_perr), 32'(got_o.perr));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic fs);
    ser_valid   = 1'b1;
    ser_bit     = b;
    frame_start = fs;
    tick();
    ser_valid   = 1'b0;
    frame_start = 1'b0;
    ser_bit     = 1'b0;
  endtask

  // Top n bits of d, MSB first, frame_start on the first, gap idle cycles after each.
  task automatic send_bits(input logic [7:0] d, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      send_bit(d[7-i], (i == 0));
      repeat (gap) tick();
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input int gap);
    send_bits(d, 8, gap);
    send_bit(p, 1'b0);
  endtask

  // pe is the even-parity error; the odd receiver flags the opposite.
  task automatic expect_frame(input logic [7:0] d, input logic pe);
    q_e.push_back(exp_t'{data: d, perr: pe});
    q_o.push_back(exp_t'{data: d, perr: ~pe});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    ser_valid = 0; ser_bit = 0; frame_start = 0; out_ready = 1; err_clr = 0; rst_n = 0;
    repeat (3) tick();
    check("rst_out_valid", 32'(bus_e.out_valid), 0);
    check("rst_out_data", 32'(bus_e.out_data), 0);
    check("rst_out_perr", 32'(bus_e.out_perr), 0);
    check("rst_err_count", 32'(bus_e.err_count), 0);
    check("rst_sync_err", 32'(bus_e.sync_err), 0);
    check("rst_overrun", 32'(bus_e.overrun), 0);
    rst_n = 1;
    tick();

    // 0x7A has five ones: parity 1 is correct for even, wrong for odd.
    expect_frame(8'h7A, 1'b0);
    send_frame(8'h7A, 1'b1, 0);
    check("t1_latency_valid", 32'(bus_e.out_valid), 1);
    check("t1_data", 32'(bus_e.out_data), 32'h7A);
    tick();
    check("t1_valid_drop", 32'(bus_e.out_valid), 0);
    check("t1_err_e", 32'(bus_e.err_count), 0);
    check("t1_err_o", 32'(bus_o.err_count), 1);

    // 0x78 (four ones) + 1 is an even error; 0x07 (three ones) + 1 is even-correct.
    expect_frame(8'h78, 1'b1);
    send_frame(8'h78, 1'b1, 3);
    tick();
    expect_frame(8'h07, 1'b0);
    send_frame(8'h07, 1'b1, 3);
    repeat (2) tick();
    check("t2_err_e", 32'(bus_e.err_count), 1);
    check("t2_err_o", 32'(bus_o.err_count), 2);

    // Aborted partial frame followed by a full 0xCC + 0.
    send_bits(8'hCC, 4, 0);
    expect_frame(8'hCC, 1'b0);
    send_frame(8'hCC, 1'b0, 0);
    repeat (2) tick();
    check("t3_sync_e", 32'(sync_cnt_e), 1);
    check("t3_sync_o", 32'(sync_cnt_o), 1);
    check("t3_err_e", 32'(bus_e.err_count), 1);
    check("t3_err_o", 32'(bus_o.err_count), 3);

    // Backpressure: second frame overruns and is dropped.
    out_ready = 0;
    expect_frame(8'h7A, 1'b0);
    send_frame(8'h7A, 1'b1, 0);
    send_frame(8'hCC, 1'b0, 0);
    tick();
    check("t4_held_valid", 32'(bus_e.out_valid), 1);
    check("t4_held_data", 32'(bus_e.out_data), 32'h7A);
    check("t4_held_perr", 32'(bus_e.out_perr), 0);
    check("t4_overrun_e", 32'(ovr_cnt_e), 1);
    check("t4_overrun_o", 32'(ovr_cnt_o), 1);
    check("t4_err_e", 32'(bus_e.err_count), 1);
    check("t4_err_o", 32'(bus_o.err_count), 4);
    out_ready = 1;
    tick();
    check("t4_valid_drop", 32'(bus_e.out_valid), 0);
    check("t4_drained", 32'(q_e.size()), 0);

    // 0x07 + 0 is even-bad/odd-good; 0x07 + 1 the reverse.
    expect_frame(8'h07, 1'b1);
    send_frame(8'h07, 1'b0, 0);
    expect_frame(8'h07, 1'b0);
    send_frame(8'h07, 1'b1, 0);
    repeat (2) tick();
    check("t5_err_e", 32'(bus_e.err_count), 2);
    check("t5_err_o", 32'(bus_o.err_count), 5);
    for (int i = 0; i < 260; i++) begin
      expect_frame(8'h07, 1'b0);
      send_frame(8'h07, 1'b1, 0);
    end
    repeat (2) tick();
    check("t5_sat_o", 32'(bus_o.err_count), 32'hFF);
    check("t5_nosat_e", 32'(bus_e.err_count), 2);
    err_clr = 1;
    tick();
    err_clr = 0;
    check("t5_clr_e", 32'(bus_e.err_count), 0);
    check("t5_clr_o", 32'(bus_o.err_count), 0);
    // Clear held across an even-bad frame load: clear wins.
    err_clr = 1;
    expect_frame(8'h07, 1'b1);
    send_frame(8'h07, 1'b0, 0);
    err_clr = 0;
    tick();
    check("t5_clr_wins_e", 32'(bus_e.err_count), 0);

    // Reset in the middle of a frame.
    expect_frame(8'h07, 1'b1);
    send_frame(8'h07, 1'b0, 0);
    repeat (2) tick();
    check("t6_pre_err_e", 32'(bus_e.err_count), 1);
    send_bits(8'hCC, 5, 0);
    rst_n = 0;
    #1;
    check("t6_rst_valid", 32'(bus_e.out_valid), 0);
    check("t6_rst_data", 32'(bus_e.out_data), 0);
    check("t6_rst_err_e", 32'(bus_e.err_count), 0);
    tick();
    rst_n = 1;
    tick();
    expect_frame(8'hCC, 1'b0);
    send_frame(8'hCC, 1'b0, 0);
    repeat (2) tick();
    check("t6_err_e", 32'(bus_e.err_count), 0);
    check("t6_err_o", 32'(bus_o.err_count), 1);
    check("t6_data", 32'(bus_e.out_data), 32'hCC);
    check("t6_sync_e", 32'(sync_cnt_e), 1);
    check("t6_overrun_e", 32'(ovr_cnt_e), 1);

    repeat (3) tick();
    check("final_q_e", 32'(q_e.size()), 0);
    check("final_q_o", 32'(q_o.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
